// File: rtl/alu_pkg.sv
// Shared encodings for the 16-bit ALU issue path: op codes, controller states, flag bits.
package alu_pkg;
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_DIV = 3'b101;

   localparam int FLAG_C = 3;
   localparam int FLAG_V = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_Z = 0;

   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

   // 11x encodings are reserved
   function automatic logic op_legal(input logic [2:0] op);
      return op <= OP_DIV;
   endfunction
endpackage

// File: rtl/regfile_nx16.sv
// NREGS x 16 register file: two asynchronous read ports, one synchronous write port.
module regfile_nx16 #(
   parameter int NREGS  = 8,
   parameter bit RF_CLR = 1'b1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [15:0]   wdata,
   input  logic [AW-1:0] raddr1,
   input  logic [AW-1:0] raddr2,
   output logic [15:0]   rdata1,
   output logic [15:0]   rdata2
);
   logic [15:0] regs [NREGS];

   always_ff @(posedge clk) begin
      if (RF_CLR && rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata1 = regs[raddr1];
   assign rdata2 = regs[raddr2];
endmodule

// File: rtl/alu_issue_ctrl_16bit.sv
// Issue controller for the 16-bit ALU: reads operands, drives the ALU, writes back
// the result and holds a response until the consumer accepts it.
module alu_issue_ctrl_16bit
   import alu_pkg::*;
#(
   parameter int NREGS  = 8,
   parameter bit RF_CLR = 1'b1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [2:0]    cmd_op,
   input  logic [AW-1:0] cmd_rd,
   input  logic [AW-1:0] cmd_rs1,
   input  logic [AW-1:0] cmd_rs2,
   input  logic          ld_en,
   input  logic [AW-1:0] ld_addr,
   input  logic [15:0]   ld_data,
   output logic [15:0]   alu_a,
   output logic [15:0]   alu_b,
   output logic          alu_sub,
   output logic [2:0]    alu_op_select,
   input  logic [15:0]   alu_result,
   input  logic          alu_cout,
   input  logic          alu_overflow,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [15:0]   rsp_data,
   output logic          rsp_err,
   output logic [3:0]    flags
);
   state_t        state, state_nxt;
   logic [AW-1:0] rd_q;
   logic          exec_ok;
   logic          we;
   logic [AW-1:0] waddr;
   logic [15:0]   wdata;
   logic [15:0]   rdata1, rdata2;

   // alu_b is already registered, so the divide-by-zero test sees the real divisor
   assign exec_ok = op_legal(alu_op_select) && !(alu_op_select == OP_DIV && alu_b == 16'd0);

   assign cmd_ready = (state == ST_IDLE);
   assign rsp_valid = (state == ST_RESP);

   always_comb begin
      state_nxt = state;
      we        = 1'b0;
      waddr     = ld_addr;
      wdata     = ld_data;
      case (state)
         ST_IDLE: begin
            if (cmd_valid) state_nxt = ST_EXEC;
            else if (ld_en) we = 1'b1;
         end
         ST_EXEC: begin
            state_nxt = ST_RESP;
            if (exec_ok) begin
               we    = 1'b1;
               waddr = rd_q;
               wdata = alu_result;
            end
         end
         ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      // reset aborts any in-flight writeback even when the file itself is not cleared
      if (rst) we = 1'b0;
   end

   regfile_nx16 #(.NREGS(NREGS), .RF_CLR(RF_CLR)) u_rf (
      .clk    (clk),
      .rst    (rst),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .raddr1 (cmd_rs1),
      .raddr2 (cmd_rs2),
      .rdata1 (rdata1),
      .rdata2 (rdata2)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         rd_q          <= '0;
         alu_a         <= '0;
         alu_b         <= '0;
         alu_sub       <= 1'b0;
         alu_op_select <= '0;
         rsp_data      <= '0;
         rsp_err       <= 1'b0;
         flags         <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: if (cmd_valid) begin
               rd_q          <= cmd_rd;
               alu_a         <= rdata1;
               alu_b         <= rdata2;
               alu_op_select <= cmd_op;
               alu_sub       <= (cmd_op == OP_SUB);
            end
            ST_EXEC: begin
               if (exec_ok) begin
                  rsp_data       <= alu_result;
                  rsp_err        <= 1'b0;
                  flags[FLAG_C]  <= alu_cout;
                  flags[FLAG_V]  <= alu_overflow;
                  flags[FLAG_N]  <= alu_result[15];
                  flags[FLAG_Z]  <= (alu_result == 16'd0);
               end else begin
                  rsp_data <= '0;
                  rsp_err  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
